// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Requester ids, response kinds and the address legality check.
package dmem_arb_pkg;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    RSP_READ = 2'd0,
    RSP_WACK = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_kind_e;

  // Word-aligned and inside the memory.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr < mem_bytes);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the data-memory arbiter.
// DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority with an r1 starvation guard.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic [1:0]       valid,
  input  logic [CNT_W-1:0] wait_cnt,
  input  logic             rr_last,
  output logic [1:0]       grant
);

  always_comb begin
    grant = valid;
    if (valid[0] && valid[1]) begin
`ifdef DMEM_ARB_RR_EN
      // rr_last holds the id granted most recently; the other side wins a conflict.
      grant = (rr_last == REQ_DBG) ? 2'b01 : 2'b10;
`else
      grant = (wait_cnt >= CNT_W'(MAX_WAIT)) ? 2'b10 : 2'b01;
`endif
    end
  end

`ifdef DMEM_ARB_RR_EN
  logic unused_wait;
  assign unused_wait = ^wait_cnt;
`else
  logic unused_rr;
  assign unused_rr = rr_last;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the write port and read port A between r0 (CPU) and r1 (debug/DMA).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [1:0]       grant;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rr_last_q, rr_last_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  rsp_kind_e        rsp_kind_q, rsp_kind_d;

  logic             acc, acc_id, acc_we, acc_ok;
  logic [31:0]      acc_addr, acc_wdata;
  logic             rvalid_any;
  logic [31:0]      rsp_rdata;

  dmem_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_pick (
    .valid    ({r1_valid, r0_valid}),
    .wait_cnt (wait_cnt_q),
    .rr_last  (rr_last_q),
    .grant    (grant)
  );

  // Nothing is accepted while reset is held.
  assign r0_ready = grant[0] & ~reset;
  assign r1_ready = grant[1] & ~reset;

  always_comb begin
    acc       = r0_ready | r1_ready;
    acc_id    = r1_ready ? REQ_DBG : REQ_CPU;
    acc_we    = r1_ready ? r1_we    : r0_we;
    acc_addr  = r1_ready ? r1_addr  : r0_addr;
    acc_wdata = r1_ready ? r1_wdata : r0_wdata;
    acc_ok    = addr_ok(acc_addr, MEM_BYTES);

    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (acc && acc_ok) begin
      if (acc_we) begin
        mem_we    = 1'b1;
        mem_waddr = acc_addr;
        mem_wdata = acc_wdata;
      end else begin
        mem_raddr = acc_addr;
      end
    end
  end

  always_comb begin
    rsp_valid_d = acc;
    rsp_id_d    = acc ? acc_id : rsp_id_q;
    rsp_kind_d  = rsp_kind_q;
    if (acc) begin
      if (!acc_ok)     rsp_kind_d = RSP_ERR;
      else if (acc_we) rsp_kind_d = RSP_WACK;
      else             rsp_kind_d = RSP_READ;
    end
  end

  always_comb begin
    rr_last_d  = rr_last_q;
    wait_cnt_d = wait_cnt_q;
`ifdef DMEM_ARB_RR_EN
    wait_cnt_d = '0;
    if (acc) rr_last_d = acc_id;
`else
    if (r1_ready)
      wait_cnt_d = '0;
    else if (r1_valid && (wait_cnt_q < CNT_W'(MAX_WAIT)))
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      rr_last_q   <= REQ_DBG;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ_CPU;
      rsp_kind_q  <= RSP_READ;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_kind_q  <= rsp_kind_d;
    end
  end

  // Gating with reset drops a response that was in flight when reset arrived.
  assign rvalid_any = rsp_valid_q & ~reset;
  assign rsp_rdata  = (rvalid_any && (rsp_kind_q == RSP_READ)) ? mem_rdata : 32'h0;

  assign r0_rvalid = rvalid_any & (rsp_id_q == REQ_CPU);
  assign r1_rvalid = rvalid_any & (rsp_id_q == REQ_DBG);
  assign r0_rdata  = r0_rvalid ? rsp_rdata : 32'h0;
  assign r1_rdata  = r1_rvalid ? rsp_rdata : 32'h0;
  assign r0_err    = r0_rvalid & (rsp_kind_q == RSP_ERR);
  assign r1_err    = r1_rvalid & (rsp_kind_q == RSP_ERR);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a reference model.
// Expectations follow the round-robin rules when DMEM_ARB_RR_EN is defined.
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 4096;
  localparam int MAX_WAIT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_ready, r0_we, r0_rvalid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_rvalid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        mem_we;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  logic [31:0] bmem   [0:1023];
  logic [31:0] shadow [0:1023];
  logic        mem_load = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hC3C3_0000;
  endfunction

  // Synchronous-read memory behind the arbiter.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) bmem[i] <= init_val(i);
    end else begin
      if (mem_we) bmem[mem_waddr[11:2]] <= mem_wdata;
      mem_rdata <= bmem[mem_raddr[11:2]];
    end
  end

  task automatic idle_inputs();
    r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    logic [166:0] obs;
    reset = 1;
    r0_valid = 1; r0_we = 0; r0_addr = 32'h20;
    repeat (2) begin
      @(negedge clk); #1;
      obs = {r0_ready, r1_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
             r0_rvalid, r0_err, r0_rdata, r1_rvalid, r1_err, r1_rdata};
      cmp_cnt++;
      if (obs !== '0) begin
        mis_cnt++;
        $display("FAIL reset_outputs got %h expected 0", obs);
      end
    end
    @(negedge clk);
    reset = 0; #1;
    cmp_cnt++;
    if ({r0_ready, r1_ready, mem_raddr} !== {2'b10, 32'h20}) begin
      mis_cnt++;
      $display("FAIL reset_first_accept got rdy=%b%b raddr=%h expected 10/00000020", r0_ready, r1_ready, mem_raddr);
    end
    @(negedge clk);
    r0_valid = 0; #1;
    cmp_cnt++;
    if ({r0_rvalid, r0_err, r0_rdata, r0_ready} !== {2'b10, init_val(8), 1'b0}) begin
      mis_cnt++;
      $display("FAIL reset_first_rsp got v=%b e=%b d=%h rdy=%b expected 1/0/%h/0", r0_rvalid, r0_err, r0_rdata, r0_ready, init_val(8));
    end
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    r0_valid = 1; r0_we = 1; r0_addr = 32'h10; r0_wdata = 32'hDEAD_BEEF; #1;
    cmp_cnt++;
    if ({r0_ready, mem_we, mem_waddr, mem_wdata, mem_raddr} !== {2'b11, 32'h10, 32'hDEAD_BEEF, 32'h0}) begin
      mis_cnt++;
      $display("FAIL raw_write got rdy=%b we=%b wa=%h wd=%h ra=%h", r0_ready, mem_we, mem_waddr, mem_wdata, mem_raddr);
    end
    shadow[4] = 32'hDEAD_BEEF;
    @(negedge clk);
    r0_valid = 0; r0_we = 0;
    r1_valid = 1; r1_we = 0; r1_addr = 32'h10; #1;
    cmp_cnt++;
    if ({r1_ready, mem_we, mem_raddr, r0_rvalid, r0_err, r0_rdata} !== {2'b10, 32'h10, 2'b10, 32'h0}) begin
      mis_cnt++;
      $display("FAIL raw_wack got rdy=%b we=%b ra=%h v=%b e=%b d=%h", r1_ready, mem_we, mem_raddr, r0_rvalid, r0_err, r0_rdata);
    end
    @(negedge clk);
    r1_valid = 0; #1;
    cmp_cnt++;
    if ({r1_rvalid, r1_err, r1_rdata, r0_rvalid} !== {2'b10, 32'hDEAD_BEEF, 1'b0}) begin
      mis_cnt++;
      $display("FAIL raw_read got v=%b e=%b d=%h r0v=%b expected 1/0/deadbeef/0", r1_rvalid, r1_err, r1_rdata, r0_rvalid);
    end
  endtask

  task automatic test_arb_pattern();
    logic exp1;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      r0_valid = 1; r0_we = 0; r0_addr = 32'h40;
      r1_valid = 1; r1_we = 0; r1_addr = 32'h80; #1;
`ifdef DMEM_ARB_RR_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = (i % 5) == 4;
`endif
      cmp_cnt++;
      if ({r0_ready, r1_ready} !== {~exp1, exp1}) begin
        mis_cnt++;
        $display("FAIL arb_pattern cycle %0d got rdy=%b%b expected %b%b", i, r0_ready, r1_ready, ~exp1, exp1);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_illegal();
    apply_reset();
    @(negedge clk);
    r0_valid = 1; r0_we = 1; r0_addr = 32'h1000; r0_wdata = 32'h1234_5678;
    r1_valid = 1; r1_we = 0; r1_addr = 32'h13; #1;
    cmp_cnt++;
    if ({r0_ready, r1_ready, mem_we, mem_waddr, mem_wdata, mem_raddr} !== {3'b100, 96'h0}) begin
      mis_cnt++;
      $display("FAIL illegal_w got rdy=%b%b we=%b wa=%h wd=%h ra=%h", r0_ready, r1_ready, mem_we, mem_waddr, mem_wdata, mem_raddr);
    end
    @(negedge clk);
    r0_valid = 0; r0_we = 0; #1;
    cmp_cnt++;
    if ({r1_ready, mem_we, mem_raddr, r0_rvalid, r0_err, r0_rdata} !== {2'b10, 32'h0, 2'b11, 32'h0}) begin
      mis_cnt++;
      $display("FAIL illegal_w_rsp got rdy=%b we=%b ra=%h v=%b e=%b d=%h", r1_ready, mem_we, mem_raddr, r0_rvalid, r0_err, r0_rdata);
    end
    @(negedge clk);
    r1_valid = 0; #1;
    cmp_cnt++;
    if ({r1_rvalid, r1_err, r1_rdata, r0_rvalid, mem_we} !== {2'b11, 32'h0, 2'b00}) begin
      mis_cnt++;
      $display("FAIL illegal_r_rsp got v=%b e=%b d=%h r0v=%b we=%b", r1_rvalid, r1_err, r1_rdata, r0_rvalid, mem_we);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    r0_valid = 1; r0_we = 0; r0_addr = 32'h20; #1;
    cmp_cnt++;
    if (r0_ready !== 1'b1) begin
      mis_cnt++;
      $display("FAIL inflight_accept got rdy=%b expected 1", r0_ready);
    end
    @(negedge clk);
    r0_valid = 0; reset = 1; #1;
    cmp_cnt++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
      mis_cnt++;
      $display("FAIL inflight_dropped got rvalid=%b%b expected 00", r0_rvalid, r1_rvalid);
    end
    @(negedge clk);
    reset = 0;
    r0_valid = 1; r0_addr = 32'h30;
    r1_valid = 1; r1_we = 0; r1_addr = 32'h40; #1;
    cmp_cnt++;
    if ({r0_ready, r1_ready, r0_rvalid} !== 3'b100) begin
      mis_cnt++;
      $display("FAIL inflight_restart got rdy=%b%b r0v=%b expected 10/0", r0_ready, r1_ready, r0_rvalid);
    end
    @(negedge clk);
    r0_valid = 0; #1;
    cmp_cnt++;
    if ({r1_ready, r0_rvalid, r0_rdata} !== {2'b11, shadow[12]}) begin
      mis_cnt++;
      $display("FAIL inflight_next got rdy=%b v=%b d=%h expected 1/1/%h", r1_ready, r0_rvalid, r0_rdata, shadow[12]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    logic        act [2];
    logic        we_r [2];
    logic [31:0] addr_r [2];
    logic [31:0] wd_r [2];
    int          wait_m, last_m, g;
    logic        legal;
    logic        pv, perr;
    int          pid;
    logic [31:0] pdata;
    logic [98:0] exp_req, obs_req;
    logic [67:0] exp_rsp, obs_rsp;
    logic        e_we;
    logic [31:0] e_wa, e_wd, e_ra;
    int unsigned k;

    apply_reset();
    wait_m = 0; last_m = 1; pv = 0; perr = 0; pid = 0; pdata = 0;
    for (int n = 0; n < 2; n++) begin
      act[n] = 0; we_r[n] = 0; addr_r[n] = 0; wd_r[n] = 0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && cyc < 395 && $urandom_range(0, 1) == 1) begin
          act[n]  = 1;
          we_r[n] = $urandom_range(0, 1) == 1;
          wd_r[n] = $urandom;
          k = $urandom_range(0, 9);
          if (k == 0)      addr_r[n] = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
          else if (k == 1) addr_r[n] = 32'(MEM_BYTES) + 32'($urandom_range(0, 255)) * 4;
          else             addr_r[n] = 32'($urandom_range(0, 15)) * 4;
        end
      end
      r0_valid = act[0]; r0_we = we_r[0]; r0_addr = addr_r[0]; r0_wdata = wd_r[0];
      r1_valid = act[1]; r1_we = we_r[1]; r1_addr = addr_r[1]; r1_wdata = wd_r[1];

      g = -1;
      if (act[0] && act[1]) begin
`ifdef DMEM_ARB_RR_EN
        g = (last_m == 0) ? 1 : 0;
`else
        g = (wait_m >= MAX_WAIT) ? 1 : 0;
`endif
      end else if (act[0]) g = 0;
      else if (act[1])     g = 1;

      legal = 0; e_we = 0; e_wa = 0; e_wd = 0; e_ra = 0;
      if (g >= 0) begin
        legal = (addr_r[g][1:0] == 2'b00) && (addr_r[g] < 32'(MEM_BYTES));
        if (legal && we_r[g]) begin
          e_we = 1; e_wa = addr_r[g]; e_wd = wd_r[g];
        end else if (legal) begin
          e_ra = addr_r[g];
        end
      end
      exp_req = {g == 0, g == 1, e_we, e_wa, e_wd, e_ra};
      exp_rsp = {pv && pid == 0, pv && pid == 0 && perr, (pv && pid == 0) ? pdata : 32'h0,
                 pv && pid == 1, pv && pid == 1 && perr, (pv && pid == 1) ? pdata : 32'h0};
      #1;
      obs_req = {r0_ready, r1_ready, mem_we, mem_waddr, mem_wdata, mem_raddr};
      obs_rsp = {r0_rvalid, r0_err, r0_rdata, r1_rvalid, r1_err, r1_rdata};
      cmp_cnt++;
      if (obs_req !== exp_req) begin
        mis_cnt++;
        $display("FAIL rnd_req cycle %0d got %h expected %h", cyc, obs_req, exp_req);
      end
      cmp_cnt++;
      if (obs_rsp !== exp_rsp) begin
        mis_cnt++;
        $display("FAIL rnd_rsp cycle %0d got %h expected %h", cyc, obs_rsp, exp_rsp);
      end

      pv = g >= 0; pid = g; perr = !legal; pdata = 0;
      if (g >= 0) begin
        if (legal && !we_r[g]) pdata = shadow[addr_r[g][11:2]];
        if (legal && we_r[g])  shadow[addr_r[g][11:2]] = wd_r[g];
        act[g] = 0;
        last_m = g;
      end
      if (g == 1)      wait_m = 0;
      else if (act[1]) wait_m = wait_m + 1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1 mem_load = 0;
    test_reset();
    test_write_then_read();
    test_arb_pattern();
    test_illegal();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
